imem_loader: RTL and testbench

//  Writer side of the CPU instruction-memory port: accepts a framed byte stream and writes
//  32-bit words into the 4096x32 instruction RAM (address = word index, wren/data/address).

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_word_packer.sv | 36 +++
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Checksum support is compiled in only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM} ldr_state_t;

  localparam int WORD_BYTES = 4;

  // Plain vector encodings of the loader states, used for the state register.
  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_CNT_LO = CNT_LO;
  localparam logic [2:0] ST_CNT_HI = CNT_HI;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_CSUM   = CSUM;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects bytes LSB-first into 32-bit words; word_valid_o fires together with the 4th byte.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LastLane = 2'(WORD_BYTES - 1);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;

  // Earlier bytes slide down so the first byte ends up in the low lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else if (clear_i) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else if (valid_i) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  assign word_valid_o = valid_i && (lane_q == LastLane);
  assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 4096x32 instruction RAM; holds the core in reset while loading.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_wren_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_written_o
);

  localparam logic [16:0]       MaxWords = 17'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              ready_q;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        abort_act;
  logic        byte_acc;
  logic        pack_valid;
  logic        pack_clr;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] n_full;
  logic        last_word;
  logic        do_finish;
  logic        do_fail;

  // Abort only counts mid-frame, and it swallows any byte offered in the same cycle.
  assign abort_act  = abort_i && (state_q != ST_IDLE);
  assign byte_acc   = in_valid_i && ready_q && !abort_act;
  assign pack_valid = byte_acc && (state_q == ST_DATA);
  assign n_full     = {in_data_i, cnt_q[7:0]};
  assign last_word  = (16'(words_q) + 16'd1) == cnt_q;

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (pack_clr),
    .valid_i      (pack_valid),
    .byte_i       (in_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    words_d    = words_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wren_d = 1'b0;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    pack_clr   = 1'b0;
    do_finish  = 1'b0;
    do_fail    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (abort_act) begin
      do_fail = 1'b1;
    end else if (byte_acc) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data_i == SYNC_BYTE) begin
            state_d  = ST_CNT_LO;
            done_d   = 1'b0;
            err_d    = 1'b0;
            words_d  = '0;
            hold_d   = 1'b1;
            pack_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d   = 8'd0;
`endif
          end
        end
        ST_CNT_LO: begin
          cnt_d[7:0] = in_data_i;
          state_d    = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          cnt_d = n_full;
          if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            do_finish = 1'b1;
`endif
          end else if ({1'b0, n_full} > MaxWords) begin
            do_fail = 1'b1;
          end else begin
            state_d   = ST_DATA;
            wr_addr_d = BaseAddr;
          end
        end
        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data_i;
`endif
          if (word_valid) begin
            mem_wren_d = 1'b1;
            mem_addr_d = wr_addr_q;
            mem_data_d = word;
            wr_addr_d  = wr_addr_q + 1'b1;
            words_d    = words_q + 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              do_finish = 1'b1;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (in_data_i == csum_q) do_finish = 1'b1;
          else                     do_fail   = 1'b1;
        end
`endif
        default: begin
          do_fail = 1'b1;
        end
      endcase
    end

    if (do_fail) begin
      state_d  = ST_IDLE;
      err_d    = 1'b1;
      hold_d   = 1'b1;
      pack_clr = 1'b1;
    end else if (do_finish) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      wr_addr_q  <= BaseAddr;
      words_q    <= '0;
      mem_addr_q <= BaseAddr;
      mem_data_q <= 32'd0;
      mem_wren_q <= 1'b0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      words_q    <= words_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      ready_q    <= 1'b1;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready_o      = ready_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_o      = mem_data_q;
  assign mem_wren_o      = mem_wren_q;
  assign cpu_hold_o      = hold_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign words_written_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [43:0] wr_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i = 8'd0;
  logic        abort_i = 1'b0;
  logic        in_ready_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_wren_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [12:0] words_written_o;

  int n_checks = 0;
  int n_pass   = 0;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  logic exp_done, exp_err, exp_hold;
  int   exp_words;

  imem_loader dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid_i),
    .in_data_i       (in_data_i),
    .in_ready_o      (in_ready_o),
    .abort_i         (abort_i),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_wren_o      (mem_wren_o),
    .cpu_hold_o      (cpu_hold_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .words_written_o (words_written_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (mem_wren_o === 1'b1) got_q.push_back({mem_addr_o, mem_data_o});
  end

  // Reference: parse one whole frame (starting with the sync byte) from its byte list.
  task automatic model_frame(input byte_q_t f, input int abort_idx);
    int n;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_words = 0;
    n = int'(f[1]) + 256 * int'(f[2]);
    x = 8'd0;
    if (abort_idx >= 1 && abort_idx <= 2) exp_err = 1'b1;
    else if (n > 4096) exp_err = 1'b1;
    else begin
      for (int k = 0; k < n; k++) begin
        if (abort_idx >= 0 && abort_idx <= 6 + 4 * k) break;
        exp_q.push_back({12'(k % 4096), f[6+4*k], f[5+4*k], f[4+4*k], f[3+4*k]});
        x = x ^ f[3+4*k] ^ f[4+4*k] ^ f[5+4*k] ^ f[6+4*k];
        exp_words++;
      end
      if (exp_words != n) exp_err = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      else if (abort_idx == 3 + 4 * n) exp_err = 1'b1;
      else if (f[3+4*n] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
`else
      else exp_done = 1'b1;
`endif
    end
    exp_hold = !exp_done;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ab);
    in_valid_i = 1'b1; in_data_i = b; abort_i = ab;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t f, input int abort_idx, input bit gaps);
    for (int i = 0; i < f.size(); i++) begin
      if (i == abort_idx) begin
        send_byte(f[i], 1'b1);
        break;
      end
      send_byte(f[i], 1'b0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1;
      end
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  function automatic byte_q_t make_frame(input int n);
    byte_q_t f;
    logic [7:0] b, x;
    x = 8'd0;
    f.push_back(8'hA5);
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(x);
`endif
    return f;
  endfunction

  task automatic test_reset;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({in_ready_o, mem_wren_o, cpu_hold_o, busy_o, done_o, err_o} !== 6'b001000)
      $display("[TB] FAIL reset_flags got=%b want=001000",
               {in_ready_o, mem_wren_o, cpu_hold_o, busy_o, done_o, err_o});
    else n_pass++;
    n_checks++;
    if ({mem_addr_o, mem_data_o, words_written_o} !== 57'd0)
      $display("[TB] FAIL reset_values addr=%h data=%h words=%0d want all zero",
               mem_addr_o, mem_data_o, words_written_o);
    else n_pass++;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (in_ready_o !== 1'b1) $display("[TB] FAIL ready_after_reset got=%b want=1", in_ready_o);
    else n_pass++;
  endtask

  task automatic test_two_words;
    byte_q_t f;
    logic [7:0] x;
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    x = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88;
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(x);
`endif
    got_q.delete();
    send_byte(f[0], 1'b0);
    n_checks++;
    if ({busy_o, cpu_hold_o} !== 2'b11) $display("[TB] FAIL two_words_busy got=%b want=11", {busy_o, cpu_hold_o});
    else n_pass++;
    f.delete(0);
    send_frame(f, -1, 1'b0);
    n_checks++;
    if (got_q.size() != 2) $display("[TB] FAIL two_words_count got=%0d want=2", got_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_q[0] !== {12'd0, 32'h44332211} || got_q[1] !== {12'd1, 32'h88776655})
        $display("[TB] FAIL two_words_data got=%h,%h want=000_44332211,001_88776655", got_q[0], got_q[1]);
      else n_pass++;
    end
    n_checks++;
    if ({done_o, err_o, cpu_hold_o, busy_o, words_written_o} !== {4'b1000, 13'd2})
      $display("[TB] FAIL two_words_status got=%b/%0d want=1000/2",
               {done_o, err_o, cpu_hold_o, busy_o}, words_written_o);
    else n_pass++;
  endtask

  task automatic test_idle_hold;
    send_byte(8'h3C, 1'b0);
    in_valid_i = 1'b0; abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if ({done_o, err_o, cpu_hold_o, busy_o} !== 4'b1000)
      $display("[TB] FAIL idle_abort_ignored got=%b want=1000", {done_o, err_o, cpu_hold_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_zero_count;
    byte_q_t f;
    f = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    got_q.delete();
    send_frame(f, -1, 1'b0);
    n_checks++;
    if ({done_o, err_o, cpu_hold_o, got_q.size() == 0} !== 4'b1001)
      $display("[TB] FAIL zero_count got=%b/%0d writes want=100/0", {done_o, err_o, cpu_hold_o}, got_q.size());
    else n_pass++;
`ifdef IMEM_LOADER_CHECKSUM_EN
    f = '{8'hA5, 8'h00, 8'h00, 8'h01};
    send_frame(f, -1, 1'b0);
    n_checks++;
    if ({done_o, err_o, cpu_hold_o} !== 3'b011)
      $display("[TB] FAIL zero_count_badcsum got=%b want=011", {done_o, err_o, cpu_hold_o});
    else n_pass++;
`endif
  endtask

  task automatic test_oversize;
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h10};
    got_q.delete();
    send_frame(f, -1, 1'b0);
    n_checks++;
    if ({done_o, err_o, cpu_hold_o, busy_o, got_q.size() == 0} !== 5'b01101)
      $display("[TB] FAIL oversize got=%b/%0d writes want=0110/0",
               {done_o, err_o, cpu_hold_o, busy_o}, got_q.size());
    else n_pass++;
  endtask

  task automatic test_abort_recover;
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    got_q.delete();
    send_frame(f, 5, 1'b0);
    n_checks++;
    if ({done_o, err_o, cpu_hold_o, busy_o, got_q.size() == 0} !== 5'b01101)
      $display("[TB] FAIL abort got=%b/%0d writes want=0110/0", {done_o, err_o, cpu_hold_o, busy_o}, got_q.size());
    else n_pass++;
    f = make_frame(1);
    model_frame(f, -1);
    got_q.delete();
    send_frame(f, -1, 1'b0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || {done_o, err_o, cpu_hold_o} !== 3'b100)
      $display("[TB] FAIL abort_recover got=%b/%0d writes want=100/1", {done_o, err_o, cpu_hold_o}, got_q.size());
    else n_pass++;
  endtask

  task automatic test_random_frames;
    byte_q_t f;
    int ab, bad;
    for (int t = 0; t < 10; t++) begin
      f = make_frame(int'($urandom_range(1, 6)));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, f.size() - 1)) : -1;
      model_frame(f, ab);
      got_q.delete();
      send_byte(8'h5A, 1'b0);
      send_frame(f, ab, 1'b1);
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] !== exp_q[i]) bad++;
      n_checks++;
      if (got_q.size() != exp_q.size() || bad != 0)
        $display("[TB] FAIL random_writes frame=%0d got=%0d writes (%0d bad) want=%0d", t, got_q.size(), bad, exp_q.size());
      else n_pass++;
      n_checks++;
      if ({done_o, err_o, cpu_hold_o, busy_o} !== {exp_done, exp_err, exp_hold, 1'b0} ||
          int'(words_written_o) != exp_words)
        $display("[TB] FAIL random_status frame=%0d got=%b/%0d want=%b/%0d", t,
                 {done_o, err_o, cpu_hold_o, busy_o}, words_written_o, {exp_done, exp_err, exp_hold, 1'b0}, exp_words);
      else n_pass++;
    end
  endtask

  task automatic test_full_depth;
    byte_q_t f;
    int bad;
    f = make_frame(4096);
    model_frame(f, -1);
    got_q.delete();
    send_frame(f, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    n_checks++;
    if (got_q.size() != 4096 || bad != 0 || got_q[4095][43:32] !== 12'hFFF)
      $display("[TB] FAIL full_depth got=%0d writes (%0d bad) want=4096", got_q.size(), bad);
    else n_pass++;
    n_checks++;
    if ({done_o, err_o, cpu_hold_o, words_written_o} !== {3'b100, 13'd4096})
      $display("[TB] FAIL full_depth_status got=%b/%0d want=100/4096", {done_o, err_o, cpu_hold_o}, words_written_o);
    else n_pass++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    got_q.delete();
    send_frame(f, -1, 1'b0);
    n_checks++;
    if ({done_o, err_o, cpu_hold_o} !== 3'b100 || got_q.size() != 1)
      $display("[TB] FAIL csum_good got=%b/%0d want=100/1", {done_o, err_o, cpu_hold_o}, got_q.size());
    else n_pass++;
    f[7] = 8'h05;
    got_q.delete();
    send_frame(f, -1, 1'b0);
    n_checks++;
    if ({done_o, err_o, cpu_hold_o} !== 3'b011 || got_q.size() != 1 || got_q[0] !== {12'd0, 32'h04030201})
      $display("[TB] FAIL csum_bad got=%b/%0d want=011/1", {done_o, err_o, cpu_hold_o}, got_q.size());
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_write;
    byte_q_t f;
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    got_q.delete();
    foreach (f[i]) send_byte(f[i], 1'b0);
    in_valid_i = 1'b1; in_data_i = 8'h44; rst_ni = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if ({in_ready_o, mem_wren_o, cpu_hold_o, busy_o, done_o, err_o} !== 6'b001000 ||
        {mem_addr_o, mem_data_o, words_written_o} !== 57'd0)
      $display("[TB] FAIL reset_mid got=%b/%h/%h/%0d want=001000/0/0/0",
               {in_ready_o, mem_wren_o, cpu_hold_o, busy_o, done_o, err_o}, mem_addr_o, mem_data_o, words_written_o);
    else n_pass++;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (got_q.size() != 0 || busy_o !== 1'b0)
      $display("[TB] FAIL reset_mid_nowrite got=%0d writes busy=%b want=0/0", got_q.size(), busy_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_idle_hold();
    test_zero_count();
    test_oversize();
    test_abort_recover();
    test_random_frames();
    test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
